// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage.
// Holds npc_op codes, FSM states and the NOP word.
package if_pkg;

    typedef enum logic [1:0] {
        NPC_PC4  = 2'b00,
        NPC_BR   = 2'b01,
        NPC_JAL  = 2'b10,
        NPC_JALR = 2'b11
    } npc_op_e;

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALT
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/if_stage_npc_calc.sv
// Next-PC selector for the fetch stage (combinational).
// In: pc, npc_op, imm, alu_c. Out: next_pc, misaligned.
module npc_calc
    import if_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_c,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc + 32'd4;
        unique case (npc_op)
            NPC_PC4:  next_pc = pc + 32'd4;
            NPC_BR:   next_pc = pc + imm;
            NPC_JAL:  next_pc = pc + imm;
            NPC_JALR: next_pc = alu_c & ~32'h1;
        endcase
    end

    // JALR already cleared bit 0, so any set low bit
    // means the target is not word-aligned.
    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem handshake, instret, fault.
// Ports: clk/rst, imem req/gnt/rvalid, inst/pc out, commit in.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      inst_o,
    output logic             inst_valid_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc4_o,
    input  logic             commit_i,
    input  logic [1:0]       npc_op_i,
    input  logic [31:0]      imm_i,
    input  logic [31:0]      alu_c_i,
    output logic [CNT_W-1:0] instret_o,
    output logic             fault_o
);

    state_e      state;
    logic [31:0] next_pc;
    logic        misaligned;

    npc_calc u_npc (
        .pc         (pc_o),
        .npc_op     (npc_op_i),
        .imm        (imm_i),
        .alu_c      (alu_c_i),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_BOOT;
            pc_o         <= RESET_PC;
            inst_o       <= NOP;
            inst_valid_o <= 1'b0;
            instret_o    <= '0;
            fault_o      <= 1'b0;
        end else begin
            unique case (state)
                S_BOOT: state <= S_REQ;
                S_REQ: begin
                    if (imem_gnt_i)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        inst_o       <= imem_rdata_i;
                        inst_valid_o <= 1'b1;
                        state        <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (commit_i) begin
                        inst_valid_o <= 1'b0;
                        instret_o    <= instret_o + CNT_W'(1);
                        pc_o         <= next_pc;
                        if (misaligned) begin
                            fault_o <= 1'b1;
                            state   <= S_HALT;
                        end else begin
                            state   <= S_REQ;
                        end
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    assign imem_req_o  = (state == S_REQ);
    assign imem_addr_o = pc_o;
    assign pc4_o       = pc_o + 32'd4;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the decode/control unit.
- Owns the PC register and computes the next PC from the control unit's npc_op, the sign-extended immediate and the ALU result.
- Fetches instructions over a request/grant/response memory handshake and presents one instruction at a time until the core commits it.
- Also keeps a retired-instruction counter and a sticky misaligned-target fault.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-high.
imem_req_o  out  1  fetch request; held high until granted.
imem_addr_o  out  32  fetch address; equals pc_o while the request is high.
imem_gnt_i  in  1  memory accepts the request in this cycle.
imem_rvalid_i  in  1  response data valid; earliest one cycle after the grant.
imem_rdata_i  in  32  instruction word.
inst_o  out  32  registered instruction passed to decode (op/func3/func7 fields).
inst_valid_o  out  1  inst_o holds the instruction at pc_o.
pc_o  out  32  PC of the current instruction.
pc4_o  out  32  pc_o + 4, used for the JAL/JALR write-back.
commit_i  in  1  the core has finished the current instruction; its npc_op, imm and alu_c inputs are valid in this cycle.
npc_op_i  in  2  next-PC select from the control unit.
imm_i  in  32  sign-extended immediate.
alu_c_i  in  32  ALU result; this is the JALR target.
instret_o  out  CNT_W  count of retired instructions.
fault_o  out  1  sticky misaligned-target fault.

Behaviour:
- Reset values: pc_o=RESET_PC, inst_o=32'h0000_0013 (NOP), inst_valid_o=0, imem_req_o=0, instret_o=0, fault_o=0. The FSM resets to S_BOOT.
- Reset asserted mid-transaction abandons the transaction. An imem_rvalid_i arriving after reset release is ignored because the FSM is not in S_WAIT.
- S_BOOT: lasts one cycle, then moves to S_REQ.
- S_REQ: imem_req_o=1 and imem_addr_o=pc_o. On imem_gnt_i, move to S_WAIT.
- S_WAIT: imem_req_o=0. On imem_rvalid_i, load inst_o from imem_rdata_i, set inst_valid_o=1 and move to S_VALID.
  - imem_rvalid_i is sampled only in S_WAIT; in every other state it is ignored.
- S_VALID: inst_o is held stable. On commit_i:
  - compute next_pc;
  - clear inst_valid_o next cycle;
  - increment instret_o, wrapping modulo 2^CNT_W;
  - load pc_o with next_pc;
  - move to S_REQ, or to S_HALT if next_pc[1:0] is non-zero.
- commit_i outside S_VALID has no effect.
- Best-case latency: S_REQ (with grant in the same cycle), then rvalid in S_WAIT, then commit in the first S_VALID cycle. That is 3 cycles per instruction.
- next_pc selection by npc_op_i:
  - NPC_PC4 (2'b00): pc_o + 4.
  - NPC_BR (2'b01): pc_o + imm_i. The control unit has already resolved the branch condition.
  - NPC_JAL (2'b10): pc_o + imm_i.
  - NPC_JALR (2'b11): alu_c_i & ~32'h1.
- All additions are 32-bit and wrap modulo 2^32 (e.g. 32'hFFFF_FFFC + 4 = 32'h0).
- Fault condition: the target after JALR bit-0 masking has bit 1 set, or a BR/JAL target has bits [1:0] non-zero.
  - The fault sets fault_o=1 and pc_o=the faulting target.
  - The faulting instruction is still counted in instret_o.
  - The FSM enters S_HALT.
- S_HALT: no requests, inst_valid_o=0, outputs frozen. Only rst exits this state.
- pc4_o is combinational from pc_o.

Decomposition:
- Shared package if_pkg:
  - npc_op encodings NPC_PC4/NPC_BR/NPC_JAL/NPC_JALR;
  - FSM state typedef (S_BOOT, S_REQ, S_WAIT, S_VALID, S_HALT);
  - NOP constant 32'h0000_0013.
  - The control unit is to use these same npc_op codes.
- One natural sub-module: npc_calc. It is purely combinational: pc, npc_op, imm and alu_c in; next_pc and misaligned out.

Test Plan:
1. Reset → boot fetch: rst asserted then released with RESET_PC=0 → one S_BOOT cycle, then imem_req_o=1 with imem_addr_o=0. Grant immediately, rvalid next cycle with rdata 32'h00500093 → inst_o=32'h00500093, inst_valid_o=1.
2. Sequential stream with variable latency: three instructions, rvalid delayed 0/2/5 cycles after grant, commit_i with NPC_PC4 each time → addresses 0, 4, 8. instret_o=3. inst_o stable throughout each S_VALID wait.
3. Branch/JAL: pc=0x10, npc_op=NPC_BR, imm=-8 → next fetch at 0x08. pc=0x08, NPC_JAL, imm=0x100 → fetch at 0x108, pc4_o=0x0C before the jump.
4. JALR: alu_c=0x0000_0203, NPC_JALR → bit 0 is masked to give 0x202. Bit 1 is set, so fault_o=1, the FSM halts, there is no further imem_req_o, and instret_o still increments. Separately, alu_c=0x201 → fetch at 0x200 with no fault.
5. Protocol robustness: commit_i pulsed during S_REQ/S_WAIT → ignored, pc unchanged. Spurious imem_rvalid_i in S_REQ → ignored. Grant held low for 4 cycles → request and address held stable throughout.
6. Reset mid-transaction: rst asserted in S_WAIT, and the stale rvalid arrives after release → ignored. A fresh request goes to RESET_PC. Counter wrap: CNT_W=4, 16 commits → instret_o=0.
